mem_wb_skid_reg: RTL

//  Parametrised MEM/WB pipeline register with a 2-entry skid buffer, valid/ready handshake on both sides, and synchronous flush.

---
 rtl/mem_wb_skid_reg.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg: MEM/WB pipeline register with a 2-entry skid buffer.
//
// Purpose
//   Captures MEM-stage beats behind a valid/ready handshake and presents them to write-back.
//   The final register write value is built at capture time: a load is lane-extracted and
//   sign/zero-extended, anything else passes the ALU result. Both held entries are exposed
//   for forwarding, and output handshakes are counted.
//
// Ports
//   clock_i, reset_i (async, active-high), flush_i (sync drop of everything)
//   mem_*_i / mem_ready_o : upstream beat and its handshake
//   wb_*_o  / wb_ready_i  : downstream entry (main register) and its handshake
//   fwd0_*_o              : main (older) entry, valid only when valid and writing a register
//   fwd1_*_o              : skid (younger) entry, same rule
//   wb_retire_count_o     : output handshakes since reset, wrapping
module mem_wb_skid_reg #(
    parameter int          CORE        = 0,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REG_BITS    = 5,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    input  logic                   mem_regWrite_i,
    input  logic                   mem_memRead_i,
    input  logic [1:0]             mem_load_size_i,
    input  logic                   mem_load_unsigned_i,
    input  logic [REG_BITS-1:0]    mem_rd_i,
    input  logic [DATA_WIDTH-1:0]  mem_memory_data_i,
    input  logic [DATA_WIDTH-1:0]  mem_ALU_result_i,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic                   wb_regWrite_o,
    output logic [REG_BITS-1:0]    wb_rd_o,
    output logic [DATA_WIDTH-1:0]  wb_write_data_o,
    output logic                   fwd0_valid_o,
    output logic [REG_BITS-1:0]    fwd0_rd_o,
    output logic [DATA_WIDTH-1:0]  fwd0_data_o,
    output logic                   fwd1_valid_o,
    output logic [REG_BITS-1:0]    fwd1_rd_o,
    output logic [DATA_WIDTH-1:0]  fwd1_data_o,
    output logic [COUNT_WIDTH-1:0] wb_retire_count_o
);

    localparam int unsigned OFF_BITS = $clog2(DATA_WIDTH / 8);

    // CORE only tags the instance; reject nonsense values at elaboration.
    if (CORE < 0) begin : g_bad_core
        $error("mem_wb_skid_reg: CORE must be non-negative");
    end

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e                 state_q;
    logic                   main_rw_q, skid_rw_q;
    logic [REG_BITS-1:0]    main_rd_q, skid_rd_q;
    logic [DATA_WIDTH-1:0]  main_data_q, skid_data_q;
    logic [COUNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

    logic                   in_hs, out_hs;
    logic                   beat_rw;
    logic [DATA_WIDTH-1:0]  beat_data;

    // Load extraction: shift the aligned lane down, mask the field, then extend.
    logic [OFF_BITS-1:0]    lane, aligned;
    logic [OFF_BITS+2:0]    shamt;
    logic [DATA_WIDTH-1:0]  shifted, field_mask, load_ext;
    logic                   sign_bit;

    always_comb begin
        lane       = mem_ALU_result_i[OFF_BITS-1:0];
        aligned    = lane;
        field_mask = '1;
        case (mem_load_size_i)
            2'd0: aligned = lane;
            2'd1: aligned = lane & ~OFF_BITS'(1);
            2'd2: aligned = lane & ~OFF_BITS'(3);
            default: aligned = '0;
        endcase
        shamt   = {aligned, 3'b000};
        shifted = mem_memory_data_i >> shamt;
        case (mem_load_size_i)
            2'd0: begin
                field_mask = DATA_WIDTH'(8'hFF);
                sign_bit   = shifted[7];
            end
            2'd1: begin
                field_mask = DATA_WIDTH'(16'hFFFF);
                sign_bit   = shifted[15];
            end
            2'd2: begin
                field_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                sign_bit   = shifted[31];
            end
            default: begin
                field_mask = '1;
                sign_bit   = 1'b0;
            end
        endcase
        load_ext = (shifted & field_mask) |
                   ((!mem_load_unsigned_i && sign_bit) ? ~field_mask : '0);
    end

    always_comb begin
        beat_data = mem_memRead_i ? load_ext : mem_ALU_result_i;
        // x0 is never written nor forwarded.
        beat_rw   = mem_regWrite_i & (mem_rd_i != '0);
    end

    // Ready depends only on registered state, so there is no path from wb_ready_i.
    assign mem_ready_o  = (state_q != StFull);
    assign wb_valid_o   = (state_q != StEmpty);
    assign in_hs        = mem_valid_i & mem_ready_o;
    assign out_hs       = wb_valid_o & wb_ready_i;
    assign retire_cnt_d = out_hs ? retire_cnt_q + 1'b1 : retire_cnt_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StEmpty;
            main_rw_q    <= 1'b0;
            main_rd_q    <= '0;
            main_data_q  <= '0;
            skid_rw_q    <= 1'b0;
            skid_rd_q    <= '0;
            skid_data_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            // A handshake completing alongside a flush still retires.
            retire_cnt_q <= retire_cnt_d;
            if (flush_i) begin
                state_q <= StEmpty;
            end else begin
                case (state_q)
                    StEmpty: begin
                        if (in_hs) begin
                            main_rw_q   <= beat_rw;
                            main_rd_q   <= mem_rd_i;
                            main_data_q <= beat_data;
                            state_q     <= StOne;
                        end
                    end
                    StOne: begin
                        if (in_hs && out_hs) begin
                            main_rw_q   <= beat_rw;
                            main_rd_q   <= mem_rd_i;
                            main_data_q <= beat_data;
                        end else if (in_hs) begin
                            skid_rw_q   <= beat_rw;
                            skid_rd_q   <= mem_rd_i;
                            skid_data_q <= beat_data;
                            state_q     <= StFull;
                        end else if (out_hs) begin
                            state_q <= StEmpty;
                        end
                    end
                    StFull: begin
                        if (out_hs) begin
                            main_rw_q   <= skid_rw_q;
                            main_rd_q   <= skid_rd_q;
                            main_data_q <= skid_data_q;
                            state_q     <= StOne;
                        end
                    end
                    default: state_q <= StEmpty;
                endcase
            end
        end
    end

    assign wb_regWrite_o     = main_rw_q & wb_valid_o;
    assign wb_rd_o           = main_rd_q;
    assign wb_write_data_o   = main_data_q;
    assign fwd0_valid_o      = wb_valid_o & main_rw_q;
    assign fwd0_rd_o         = main_rd_q;
    assign fwd0_data_o       = main_data_q;
    assign fwd1_valid_o      = (state_q == StFull) & skid_rw_q;
    assign fwd1_rd_o         = skid_rd_q;
    assign fwd1_data_o       = skid_data_q;
    assign wb_retire_count_o = retire_cnt_q;

endmodule
